// File: rtl/pipe_adder_pkg.sv
// Shared constants and mode encoding for the skewed pipelined adder.
package pipe_adder_pkg;

    localparam int unsigned DefWidth  = 32;
    localparam int unsigned DefStages = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit ripple-carry slice; also exposes the carry into its MSB for overflow.
module adder_chunk #(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_b,
    input  logic          i_c,
    output logic [CW-1:0] o_s,
    output logic          o_c,
    output logic          o_c_msb
);

    always_comb begin
        logic [CW:0] w_carry;
        w_carry    = '0;
        w_carry[0] = i_c;
        o_s        = '0;
        for (int i = 0; i < CW; i++) begin
            o_s[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
            w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
        o_c     = w_carry[CW];
        o_c_msb = w_carry[CW-1];
    end

endmodule

// File: rtl/pipe_adder.sv
// Skewed pipelined add/subtract: stage k resolves chunk k and forwards operands and partial sum.
// Per-stage valid bits with a ready chain give full throughput and bubble collapsing.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned STAGES = DefStages
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CW = WIDTH / STAGES;

    mode_e             w_mode;
    logic [STAGES:0]   w_en;
    logic [STAGES-1:0] w_v_src;
    logic [STAGES-1:0] r_v;

    logic [WIDTH-1:0] w_a_in  [STAGES];
    logic [WIDTH-1:0] w_b_in  [STAGES];
    logic [WIDTH-1:0] w_s_in  [STAGES];
    logic [WIDTH-1:0] w_s_new [STAGES];
    logic [CW-1:0]    w_chunk [STAGES];
    logic             w_c_in  [STAGES];
    logic             w_c_out [STAGES];
    logic             w_c_msb [STAGES];

    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];

    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_ovf;
    logic             r_zero;

    assign w_mode = mode_e'(sub);

    // A stage may load when empty or when the stage after it is loading too.
    always_comb begin
        w_en         = '0;
        w_en[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_en[k] = ~r_v[k] | w_en[k+1];
        end
    end

    assign w_v_src = STAGES'({r_v, in_valid});

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_a_in[k] = a;
            assign w_b_in[k] = (w_mode == MODE_SUB) ? ~b : b;
            assign w_s_in[k] = '0;
            assign w_c_in[k] = (w_mode == MODE_SUB) ? ~c_in : c_in;
        end else begin : g_body
            assign w_a_in[k] = r_a[k-1];
            assign w_b_in[k] = r_b[k-1];
            assign w_s_in[k] = r_s[k-1];
            assign w_c_in[k] = r_c[k-1];
        end

        adder_chunk #(
            .CW(CW)
        ) u_chunk (
            .i_a    (w_a_in[k][k*CW +: CW]),
            .i_b    (w_b_in[k][k*CW +: CW]),
            .i_c    (w_c_in[k]),
            .o_s    (w_chunk[k]),
            .o_c    (w_c_out[k]),
            .o_c_msb(w_c_msb[k])
        );

        // Chunks not yet resolved are still zero in the forwarded partial sum.
        assign w_s_new[k] = w_s_in[k] | (WIDTH'(w_chunk[k]) << (k * CW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_en[k]) r_v[k] <= w_v_src[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES - 1; k++) begin
            if (w_en[k]) begin
                r_a[k] <= w_a_in[k];
                r_b[k] <= w_b_in[k];
                r_s[k] <= w_s_new[k];
                r_c[k] <= w_c_out[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_en[STAGES-1]) begin
            r_sum   <= w_s_new[STAGES-1];
            r_c_out <= w_c_out[STAGES-1];
            r_ovf   <= w_c_out[STAGES-1] ^ w_c_msb[STAGES-1];
            r_zero  <= (w_s_new[STAGES-1] == '0);
        end
    end

    assign in_ready  = rst_n & w_en[0];
    assign out_valid = r_v[STAGES-1];
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed and randomized stall checks for pipe_adder at WIDTH=32, STAGES=4.
module tb_pipe_adder;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic         ci;
        logic [W+2:0] exp;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;

    int n_vec  = 0;
    int n_miss = 0;

    pipe_adder #(
        .WIDTH (W),
        .STAGES(4)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .c_in     (c_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .ovf      (ovf),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result packing used throughout: {c_out, ovf, zero, sum}.
    function automatic logic [W+2:0] ref_calc(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                              input logic fsub, input logic fcin);
        logic [W-1:0] eb;
        logic [W:0]   full;
        logic         fovf;
        eb   = fsub ? ~fb : fb;
        full = {1'b0, fa} + {1'b0, eb} + {{W{1'b0}}, (fsub ? ~fcin : fcin)};
        fovf = (fa[W-1] == eb[W-1]) && (full[W-1] != fa[W-1]);
        return {full[W], fovf, (full[W-1:0] == '0), full[W-1:0]};
    endfunction

    // Presents one set, then counts cycles from presentation until out_valid.
    task automatic apply_one(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                             input logic tc, output int lat, output logic [W+2:0] got);
        bit found;
        found = 1'b0;
        lat   = 99;
        got   = '0;
        @(posedge clk);
        #1;
        a = ta; b = tb; sub = ts; c_in = tc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (!found) begin
                @(negedge clk);
                if (out_valid) begin
                    found = 1'b1;
                    lat   = c;
                    got   = {c_out, ovf, zero, sum};
                end else begin
                    @(posedge clk);
                end
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({out_valid, in_ready, c_out, ovf, zero} !== 5'b0) begin
            n_miss++;
            $display("FAIL reset_ctl: got {ov,ir,c,ovf,z}=%b, want 00000",
                     {out_valid, in_ready, c_out, ovf, zero});
        end
        n_vec++;
        if (sum !== '0) begin
            n_miss++;
            $display("FAIL reset_sum: got %h, want 00000000", sum);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        vec_t         v [4];
        int           lat;
        logic [W+2:0] got;
        v[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {3'b101, 32'h0000_0000}};
        v[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {3'b010, 32'h8000_0000}};
        v[2] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, {3'b000, 32'h2345_678A}};
        v[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {3'b111, 32'h0000_0000}};
        for (int i = 0; i < 4; i++) begin
            apply_one(v[i].a, v[i].b, v[i].s, v[i].ci, lat, got);
            n_vec++;
            if (lat !== 4) begin
                n_miss++;
                $display("FAIL add[%0d]_latency: got %0d, want 4", i, lat);
            end
            n_vec++;
            if (got !== v[i].exp) begin
                n_miss++;
                $display("FAIL add[%0d]_result: got %h, want %h", i, got, v[i].exp);
            end
        end
    endtask

    task automatic test_sub();
        vec_t         v [4];
        int           lat;
        logic [W+2:0] got;
        v[0] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, {3'b110, 32'h7FFF_FFFF}};
        v[1] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, {3'b000, 32'hFFFF_FFFF}};
        v[2] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, {3'b000, 32'hFFFF_FFFE}};
        v[3] = '{32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, {3'b101, 32'h0000_0000}};
        for (int i = 0; i < 4; i++) begin
            apply_one(v[i].a, v[i].b, v[i].s, v[i].ci, lat, got);
            n_vec++;
            if (lat !== 4) begin
                n_miss++;
                $display("FAIL sub[%0d]_latency: got %0d, want 4", i, lat);
            end
            n_vec++;
            if (got !== v[i].exp) begin
                n_miss++;
                $display("FAIL sub[%0d]_result: got %h, want %h", i, got, v[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W+2:0] q[$];
        logic [W+2:0] exp;
        int first = -1;
        int last  = -1;
        int nout  = 0;
        int sent  = 0;
        int stall = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 32'h0F0F_0F0F; b = 32'hF00D_CAFE; sub = 1'b0; c_in = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (in_valid && !in_ready) stall++;
            if (in_valid && in_ready) begin
                q.push_back(ref_calc(a, b, sub, c_in));
                sent++;
            end
            if (out_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                nout++;
                n_vec++;
                if (q.size() == 0) begin
                    n_miss++;
                    $display("FAIL b2b_spurious: got out_valid at cycle %0d, want none", cyc);
                end else begin
                    exp = q.pop_front();
                    if ({c_out, ovf, zero, sum} !== exp) begin
                        n_miss++;
                        $display("FAIL b2b_result: got %h, want %h", {c_out, ovf, zero, sum}, exp);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (sent >= 24) begin
                in_valid = 1'b0;
            end else begin
                a    = a + 32'h0123_4567;
                b    = {b[30:0], b[31]} ^ 32'h0000_0005;
                sub  = ~sub;
                c_in = sent[0];
            end
        end
        n_vec++;
        if (first != 4) begin
            n_miss++;
            $display("FAIL b2b_first_out: got cycle %0d, want 4", first);
        end
        n_vec++;
        if (nout != 24 || last - first != 23 || stall != 0) begin
            n_miss++;
            $display("FAIL b2b_throughput: got %0d results over %0d cycles, %0d stalls; want 24/24/0",
                     nout, last - first + 1, stall);
        end
    endtask

    task automatic test_backpressure();
        logic [W+2:0] q[$];
        logic [W+2:0] exp;
        logic [W+2:0] held_val;
        bit held       = 1'b0;
        bit stall_done = 1'b0;
        int sent       = 0;
        int recvd      = 0;
        int stall_cnt  = 0;
        int cyc        = 0;
        held_val = '0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); c_in = 1'($urandom_range(0, 1));
        while (recvd < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                n_vec++;
                if (!out_valid || {c_out, ovf, zero, sum} !== held_val) begin
                    n_miss++;
                    $display("FAIL stall_hold: got ov=%b %h, want ov=1 %h", out_valid,
                             {c_out, ovf, zero, sum}, held_val);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_calc(a, b, sub, c_in));
                sent++;
            end
            if (stall_cnt == 1) begin
                n_vec++;
                if (in_ready !== 1'b0 || q.size() != 4) begin
                    n_miss++;
                    $display("FAIL stall_fill: got in_ready=%b in_flight=%0d, want 0 and 4",
                             in_ready, q.size());
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_miss++;
                    $display("FAIL bp_spurious: got result %h, want none", sum);
                end else begin
                    exp = q.pop_front();
                    if ({c_out, ovf, zero, sum} !== exp) begin
                        n_miss++;
                        $display("FAIL bp_result[%0d]: got %h, want %h", recvd,
                                 {c_out, ovf, zero, sum}, exp);
                    end
                end
                recvd++;
            end
            held     = out_valid && !out_ready;
            held_val = {c_out, ovf, zero, sum};
            @(posedge clk);
            #1;
            if (stall_cnt > 0) stall_cnt--;
            if (sent >= 200 && !stall_done) begin
                stall_cnt  = 10;
                stall_done = 1'b1;
            end
            out_ready = (stall_cnt > 0) ? 1'b0 : ($urandom_range(0, 9) < 7);
            in_valid  = (sent >= 1000) ? 1'b0 : (stall_cnt > 0) ? 1'b1 : ($urandom_range(0, 9) < 8);
            a = $urandom; b = $urandom;
            sub = 1'($urandom_range(0, 1)); c_in = 1'($urandom_range(0, 1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (recvd != 1000 || sent != 1000 || q.size() != 0) begin
            n_miss++;
            $display("FAIL bp_count: got sent=%0d recvd=%0d pending=%0d, want 1000 1000 0",
                     sent, recvd, q.size());
        end
    endtask

    task automatic test_mid_reset();
        int           lat;
        int           stale = 0;
        logic [W+2:0] got;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'h1000_0000 + i; b = 32'h0000_0100; sub = 1'b0; c_in = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL midrst_during: got out_valid=%b in_ready=%b, want 0 0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_vec++;
        if (stale != 0) begin
            n_miss++;
            $display("FAIL midrst_stale: got %0d stale results, want 0", stale);
        end
        apply_one(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, lat, got);
        n_vec++;
        if (lat !== 4) begin
            n_miss++;
            $display("FAIL midrst_latency: got %0d, want 4", lat);
        end
        n_vec++;
        if (got !== {3'b000, 32'h0000_0030}) begin
            n_miss++;
            $display("FAIL midrst_result: got %h, want %h", got, {3'b000, 32'h0000_0030});
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        c_in      = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
